// File: rtl/ps2_pkg.sv
//==============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 scancode receiver.
//               Holds the frame-receive FSM state encoding and the two
//               scancode prefix bytes (extended and break).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ps2_pkg;

    // Frame-receive FSM states. Explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Scancode prefix bytes.
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_code_fifo.sv
//==============================================================================
// Module      : ps2_code_fifo
// Description : First-word-fall-through FIFO for received scancodes.
//               The head entry is visible on head_data whenever head_valid
//               is high. A push while full is dropped (overflow pulse) unless
//               a pop happens in the same cycle, in which case both proceed.
// Revision    : 1.0 - initial release
//
// Parameters  : WIDTH - entry width in bits
//               DEPTH - number of entries (power of 2, minimum 2)
// Ports       : clk        - system clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               push       - write push_data this cycle
//               push_data  - entry to write
//               pop        - remove head entry this cycle
//               head_data  - entry at the FIFO head
//               head_valid - FIFO not empty
//               count      - current occupancy
//               overflow   - one-cycle pulse when a push was dropped
//==============================================================================
`default_nettype none

module ps2_code_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic full, empty, pop_ok, push_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop & ~empty;
    // When full, a simultaneous pop frees the slot the push will use.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push & full & ~pop_ok;

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = ~empty;
    assign count      = count_q;
    assign overflow   = overflow_q;

endmodule : ps2_code_fifo

`default_nettype wire

// File: rtl/ps2_scan_rx.sv
//==============================================================================
// Module      : ps2_scan_rx
// Description : PS/2 keyboard scancode receiver. Synchronises the raw PS/2
//               clock and data lines, receives 11-bit frames (start, 8 data
//               LSB first, odd parity, stop) sampled on ps2_clk falling edges,
//               checks parity/stop/inter-edge timeout and queues good bytes
//               in a first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
//
// Build option: PS2_PREFIX_DECODE_EN - when defined, 0xE0/0xF0 prefix bytes
//               are absorbed into pending flags and attached to the next
//               non-prefix code (code_ext / code_break). When undefined,
//               every good byte is queued and both flags read 0.
//
// Parameters  : SYNC_STAGES - synchroniser depth on ps2_clk/ps2_data (>= 2)
//               TIMEOUT_CYC - max clk cycles between falling edges in a frame
//               FIFO_DEPTH  - scancode FIFO entries (power of 2, >= 2)
// Ports       : clk        - system clock (rising edge)
//               rst_n      - asynchronous active-low reset
//               ps2_clk    - raw PS/2 clock line
//               ps2_data   - raw PS/2 data line
//               code_data  - scancode at FIFO head
//               code_break - head code was preceded by 0xF0
//               code_ext   - head code was preceded by 0xE0
//               code_valid - FIFO not empty
//               code_ready - consumer accepts the head entry
//               frame_err  - one-cycle pulse on parity/stop/timeout error
//               overflow   - one-cycle pulse when a good frame is dropped
//               fifo_count - FIFO occupancy
//==============================================================================
`default_nettype none

module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    code_data,
    output logic                          code_break,
    output logic                          code_ext,
    output logic                          code_valid,
    input  logic                          code_ready,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_PREFIX_DECODE_EN
    localparam int ENTRY_W = 10;  // {break, ext, code}
`else
    localparam int ENTRY_W = 8;   // code only
`endif

    // ------------------------------------------------------------------
    // Input synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   ps2_clk_s, ps2_data_s, fall;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = dat_sync_q[SYNC_STAGES-1];
    assign fall       = clk_prev_q & ~ps2_clk_s;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d = ps2_clk_s;
    end

    // ------------------------------------------------------------------
    // Frame-receive FSM
    // ------------------------------------------------------------------
    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q, push_data_d;
`ifdef PS2_PREFIX_DECODE_EN
    logic             pend_brk_q, pend_brk_d;
    logic             pend_ext_q, pend_ext_d;
    logic             push_brk_q, push_brk_d;
    logic             push_ext_q, push_ext_d;
`endif
    logic             frame_good;

    // Odd parity over data+parity, and stop bit (sampled now) must be 1.
    assign frame_good = (^{shift_q, parity_q}) & ps2_data_s;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        frame_err_d = 1'b0;
        push_d      = 1'b0;
        push_data_d = push_data_q;
`ifdef PS2_PREFIX_DECODE_EN
        pend_brk_d  = pend_brk_q;
        pend_ext_d  = pend_ext_q;
        push_brk_d  = push_brk_q;
        push_ext_d  = push_ext_q;
`endif

        if ((state_q == IDLE) || fall) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (fall && !ps2_data_s) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {ps2_data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = ps2_data_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (frame_good) begin
`ifdef PS2_PREFIX_DECODE_EN
                        if (shift_q == PS2_PFX_EXT) begin
                            pend_ext_d = 1'b1;
                        end else if (shift_q == PS2_PFX_BRK) begin
                            pend_brk_d = 1'b1;
                        end else begin
                            push_d      = 1'b1;
                            push_data_d = shift_q;
                            push_brk_d  = pend_brk_q;
                            push_ext_d  = pend_ext_q;
                            pend_brk_d  = 1'b0;
                            pend_ext_d  = 1'b0;
                        end
`else
                        push_d      = 1'b1;
                        push_data_d = shift_q;
`endif
                    end else begin
                        frame_err_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
                        pend_brk_d  = 1'b0;
                        pend_ext_d  = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Stalled mid-frame: give up and resynchronise on the next start bit.
        if ((state_q != IDLE) && !fall && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC))) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
            pend_brk_d  = 1'b0;
            pend_ext_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Idle-high synchroniser reset avoids a false edge on release.
            clk_sync_q  <= '1;
            dat_sync_q  <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
`ifdef PS2_PREFIX_DECODE_EN
            pend_brk_q  <= 1'b0;
            pend_ext_q  <= 1'b0;
            push_brk_q  <= 1'b0;
            push_ext_q  <= 1'b0;
`endif
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_cnt_q   <= tmo_cnt_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
`ifdef PS2_PREFIX_DECODE_EN
            pend_brk_q  <= pend_brk_d;
            pend_ext_q  <= pend_ext_d;
            push_brk_q  <= push_brk_d;
            push_ext_q  <= push_ext_d;
`endif
        end
    end

    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // Scancode FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_pop;

`ifdef PS2_PREFIX_DECODE_EN
    assign push_entry = {push_brk_q, push_ext_q, push_data_q};
`else
    assign push_entry = push_data_q;
`endif

    assign fifo_pop = code_valid & code_ready;

    ps2_code_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_q),
        .push_data  (push_entry),
        .pop        (fifo_pop),
        .head_data  (head_entry),
        .head_valid (code_valid),
        .count      (fifo_count),
        .overflow   (overflow)
    );

`ifdef PS2_PREFIX_DECODE_EN
    assign code_data  = head_entry[7:0];
    assign code_ext   = head_entry[8];
    assign code_break = head_entry[9];
`else
    assign code_data  = head_entry;
    assign code_ext   = 1'b0;
    assign code_break = 1'b0;
`endif

endmodule : ps2_scan_rx

`default_nettype wire

// File: tb/tb_ps2_scan_rx.sv
//==============================================================================
// Module      : tb_ps2_scan_rx
// Description : Self-checking bench for ps2_scan_rx. Drives PS/2 frames
//               bit-by-bit and compares the queued scancodes, error pulses
//               and overflow pulses against a queue-based reference model.
//               Honours PS2_PREFIX_DECODE_EN in its expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ps2_scan_rx;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 10;   // clk cycles per PS/2 clock half period

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_ready = 1'b0;
    logic [7:0] code_data;
    logic       code_break, code_ext, code_valid, frame_err, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    ps2_scan_rx #(
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (TMO),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_data  (code_data),
        .code_break (code_break),
        .code_ext   (code_ext),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef logic [9:0] ent_t;   // {break, ext, code}
    ent_t exp_q[$];
    int   exp_err = 0;
    int   exp_ovf = 0;
    bit   pend_brk = 1'b0;
    bit   pend_ext = 1'b0;

    task automatic model_frame(input logic [7:0] d, input bit good);
        ent_t e;
        if (!good) begin
            exp_err++;
            pend_brk = 1'b0;
            pend_ext = 1'b0;
            return;
        end
`ifdef PS2_PREFIX_DECODE_EN
        if (d == 8'hE0) begin pend_ext = 1'b1; return; end
        if (d == 8'hF0) begin pend_brk = 1'b1; return; end
        e = {pend_brk, pend_ext, d};
        pend_brk = 1'b0;
        pend_ext = 1'b0;
`else
        e = {2'b00, d};
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf++;
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_brk = 1'b0;
        pend_ext = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int   err_seen = 0;
    int   ovf_seen = 0;
    int   stab_viol = 0;
    bit   hold_prev = 1'b0;
    ent_t head_prev = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (frame_err) err_seen++;
            if (overflow)  ovf_seen++;
            if (hold_prev && ({code_break, code_ext, code_data} !== head_prev)) stab_viol++;
            hold_prev = code_valid && !code_ready;
            head_prev = {code_break, code_ext, code_data};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic tx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        send_bits(frame_bits(d, bad_par, bad_stop), 11);
        model_frame(d, !bad_par && !bad_stop);
        wait_cyc(HALF);
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_frame_err_cnt"}, err_seen, exp_err);
        check_eq({tag, "_overflow_cnt"}, ovf_seen, exp_ovf);
        check_eq({tag, "_fifo_count"}, fifo_count, exp_q.size());
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            check_eq({tag, "_valid"}, code_valid, 1'b1);
            check_eq({tag, "_head"}, {code_break, code_ext, code_data}, exp_q[0]);
            void'(exp_q.pop_front());
            code_ready = 1'b1;
            @(negedge clk);
            code_ready = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, "_empty"}, code_valid, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] d;
        int         n, r, bad;

        // Reset state
        wait_cyc(4);
        check_eq("rst_valid", code_valid, 1'b0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_outs", {code_data, code_break, code_ext, frame_err, overflow}, 12'h000);
        rst_n = 1'b1;
        wait_cyc(5);

        // Good frame 0x1C (parity 0)
        tx(8'h1C, 1'b0, 1'b0);
        check_eq("1c_valid", code_valid, 1'b1);
        check_eq("1c_data", code_data, 8'h1C);
        check_counts("1c");
        drain("1c");

        // Bad parity 0x1C
        tx(8'h1C, 1'b1, 1'b0);
        check_counts("1c_badpar");
        check_eq("1c_badpar_valid", code_valid, 1'b0);

        // Bad stop bit
        tx(8'h3A, 1'b0, 1'b1);
        check_counts("badstop");

        // Prefix handling F0, E0, 75
        tx(8'hF0, 1'b0, 1'b0);
        tx(8'hE0, 1'b0, 1'b0);
        tx(8'h75, 1'b0, 1'b0);
`ifdef PS2_PREFIX_DECODE_EN
        check_eq("pfx_count", fifo_count, 1);
        check_eq("pfx_head", {code_break, code_ext, code_data}, 10'h375);
`else
        check_eq("pfx_count", fifo_count, 3);
        check_eq("pfx_head", {code_break, code_ext, code_data}, 10'h0F0);
`endif
        check_counts("pfx");
        drain("pfx");

        // Overflow: 5 good frames into a 4-deep FIFO
        for (int i = 0; i < 5; i++) tx(8'h11 + 8'(i), 1'b0, 1'b0);
        wait_cyc(3);
        check_eq("ovf_count", fifo_count, DEPTH);
        check_eq("ovf_head", code_data, 8'h11);
        check_counts("ovf");
        drain("ovf");

        // Timeout: 5 bits then ps2_clk stops
        send_bits(frame_bits(8'h6B, 1'b0, 1'b0), 5);
        wait_cyc(TMO - HALF - 15);
        check_eq("tmo_early", err_seen, exp_err);
        wait_cyc(40);
        exp_err++;
        pend_brk = 1'b0;
        pend_ext = 1'b0;
        check_eq("tmo_fire", err_seen, exp_err);
        tx(8'h29, 1'b0, 1'b0);
        check_eq("tmo_next_data", code_data, 8'h29);
        check_counts("tmo");
        drain("tmo");

        // Reset mid-frame, then good frame 0x5A
        send_bits(frame_bits(8'h33, 1'b0, 1'b0), 4);
        rst_n = 1'b0;
        wait_cyc(3);
        check_eq("midrst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        model_reset();
        wait_cyc(3);
        tx(8'h5A, 1'b0, 1'b0);
        check_eq("midrst_data", code_data, 8'h5A);
        check_counts("midrst");
        drain("midrst");

        // Randomized batches
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      d = 8'hE0;
                else if (r == 1) d = 8'hF0;
                else             d = 8'($urandom);
                bad = $urandom_range(0, 5);
                tx(d, bad == 0, bad == 1);
            end
            check_counts("rand");
            drain("rand");
        end

        check_eq("head_stable", stab_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ps2_scan_rx

`default_nettype wire
